rtc3w_master: RTL and testbench



---
 rtl/rtc3w_master.sv | 199 +++++++++++++++++++
 tb/tb_rtc3w_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc3w_master.sv
// rtc3w_master: Avalon-MM slave that generates DS1302-style CE/SCLK/IO frames.
// Define RTC3W_IRQ_EN to add the registered completion interrupt (irq port, STATUS bit2).
module rtc3w_master #(
  parameter int CLKDIV = 50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        rtc_ce,
  output logic        rtc_sclk,
  inout  wire         rtc_io,
  output logic [2:0]  dbg_state
`ifdef RTC3W_IRQ_EN
  ,
  output logic        irq
`endif
);

  // Bus handshake: no wait states. A write takes effect on the clk edge where
  // chipselect && !write_n; a read (chipselect && write_n) is answered on
  // readdata one clk later, which otherwise holds its last value.
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_WDATA, S_RDATA, S_HOLD, S_RECOVER
  } state_t;

  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    shift_q, shift_d;
  logic          done_q, done_d;
  logic          irq_en_q, irq_en_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          io_oe, io_out;
  logic          wr, rd, tick, busy, frame_end;
  logic          unused_wd;

  assign wr        = chipselect && !write_n;
  assign rd        = chipselect && write_n;
  assign busy      = (state_q != S_IDLE);
  assign tick      = (cnt_q == CW'(CLKDIV - 1));
  assign unused_wd = ^writedata[31:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      cmd_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      cmd_q      <= cmd_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      irq_en_q   <= irq_en_d;
      readdata_q <= readdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    phase_d    = phase_q;
    bit_d      = bit_q;
    cmd_d      = cmd_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    shift_d    = shift_q;
    done_d     = done_q;
    irq_en_d   = irq_en_q;
    readdata_d = readdata_q;
    frame_end  = 1'b0;
    if (busy) cnt_d = tick ? '0 : cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        if (wr && address == 3'd1) tx_d = writedata[7:0];
        if (wr && address == 3'd0) begin
          cmd_d   = writedata[7:0];
          state_d = S_SETUP;
          phase_d = 1'b0;
          bit_d   = '0;
          done_d  = 1'b0;
        end
      end
      S_SETUP: if (tick) state_d = S_CMD;
      S_CMD, S_WDATA, S_RDATA: begin
        if (tick) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            // Last clk of the low half: the RTC's bit has been stable since the falling edge.
            if (state_q == S_RDATA) shift_d = {rtc_io, shift_q[7:1]};
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (state_q == S_CMD) state_d = cmd_q[0] ? S_RDATA : S_WDATA;
              else                  state_d = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          state_d = S_RECOVER;
          if (cmd_q[0]) rx_d = shift_q;
        end
      end
      S_RECOVER: begin
        if (tick) begin
          if (!phase_q) phase_d = 1'b1;
          else begin
            phase_d   = 1'b0;
            state_d   = S_IDLE;
            frame_end = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (wr && address == 3'd2 && writedata[1]) done_d = 1'b0;
    if (frame_end) done_d = 1'b1;
`ifdef RTC3W_IRQ_EN
    if (wr && address == 3'd2) irq_en_d = writedata[2];
`endif
    if (rd) begin
      case (address)
        3'd1:    readdata_d = {24'd0, rx_q};
        3'd2:    readdata_d = {29'd0, irq_en_q, done_q, busy};
        default: readdata_d = '0;
      endcase
    end
  end

  // The line is driven only while sclk is low at every on/off transition.
  always_comb begin
    rtc_ce   = 1'b0;
    rtc_sclk = 1'b0;
    io_oe    = 1'b0;
    io_out   = 1'b0;
    case (state_q)
      S_SETUP: begin
        rtc_ce = 1'b1;
        io_oe  = 1'b1;
        io_out = cmd_q[0];
      end
      S_CMD: begin
        rtc_ce   = 1'b1;
        rtc_sclk = phase_q;
        io_oe    = 1'b1;
        io_out   = cmd_q[bit_q];
      end
      S_WDATA: begin
        rtc_ce   = 1'b1;
        rtc_sclk = phase_q;
        io_oe    = 1'b1;
        io_out   = tx_q[bit_q];
      end
      S_RDATA: begin
        rtc_ce   = 1'b1;
        rtc_sclk = phase_q;
      end
      S_HOLD:  rtc_ce = 1'b1;
      default: ;
    endcase
  end

  assign rtc_io    = io_oe ? io_out : 1'bz;
  assign readdata  = readdata_q;
  assign dbg_state = state_q;

`ifdef RTC3W_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= done_q && irq_en_q;
  end
`endif

endmodule

// File: tb/tb_rtc3w_master.sv
// tb_rtc3w_master: randomized frames against an RTC slave model with a frame/register scoreboard.
// Build with or without RTC3W_IRQ_EN; irq checks follow the macro.
module tb_rtc3w_master;
  localparam int CLKDIV   = 4;
  localparam int CE_LEN   = 34 * CLKDIV;
  localparam int BUSY_LEN = 36 * CLKDIV;
`ifdef RTC3W_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk, reset_n, chipselect, write_n;
  logic [2:0]  address;
  logic [31:0] writedata, readdata;
  logic        rtc_ce, rtc_sclk;
  wire         rtc_io;
  logic [2:0]  dbg_state;
  logic        irq;

  rtc3w_master #(.CLKDIV(CLKDIV)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .rtc_ce(rtc_ce), .rtc_sclk(rtc_sclk), .rtc_io(rtc_io), .dbg_state(dbg_state)
`ifdef RTC3W_IRQ_EN
    , .irq(irq)
`endif
  );
`ifndef RTC3W_IRQ_EN
  assign irq = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // reference state
  logic [7:0] exp_rx, exp_tx;
  logic       exp_done, exp_irq_en;

  function automatic logic [31:0] st_exp(input logic b);
    return {29'd0, IRQ_BUILD && exp_irq_en, exp_done, b};
  endfunction

  function automatic logic [39:0] mk(input logic [7:0] c, input logic [7:0] d);
    return {16'(CE_LEN), 8'd16, c, d};
  endfunction

  // RTC slave model
  logic       m_oe, m_bit;
  logic [7:0] m_cmd, m_data, m_rbyte;
  int         m_rises, ce_len;
  logic [39:0] obs_q[$];
  logic [39:0] exp_frame_q[$];
  assign rtc_io = m_oe ? m_bit : 1'bz;

  always @(posedge rtc_ce) begin
    m_rises = 0; m_cmd = '0; m_data = '0; ce_len = 0;
  end
  always @(negedge clk) if (rtc_ce) ce_len++;
  always @(posedge rtc_sclk) begin
    if (rtc_ce) begin
      if (m_rises < 8) m_cmd[m_rises] = rtc_io;
      else if (m_rises < 16) m_data[m_rises-8] = rtc_io;
      m_rises++;
    end
  end
  always @(negedge rtc_sclk) begin
    if (rtc_ce && m_cmd[0] && m_rises >= 8 && m_rises < 16) begin
      #1;
      m_bit = m_rbyte[m_rises-8];
      m_oe  = 1'b1;
    end
  end
  always @(negedge rtc_ce) begin
    m_oe = 1'b0;
    if (reset_n) obs_q.push_back({ce_len[15:0], m_rises[7:0], m_cmd, m_data});
  end

  // frame monitor
  always @(negedge clk) begin
    logic [39:0] o, e;
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      if (exp_frame_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_frame: got 0x%0h, expected no frame", o);
      end else begin
        e = exp_frame_q.pop_front();
        check("frame ce_len", o[39:24], e[39:24]);
        check("frame sclk_rises", o[23:16], e[23:16]);
        check("frame cmd_bits", o[15:8], e[15:8]);
        check("frame data_bits", o[7:0], e[7:0]);
      end
    end
  end

  // register read scoreboard
  logic [31:0] exp_rd_q[$];
  string       exp_nm_q[$];
  logic        sb_rd, rd_pend;
  always @(posedge clk) rd_pend <= sb_rd;
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_rd_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL read_underflow: got 0x%0h, expected none", readdata);
      end else check(exp_nm_q.pop_front(), readdata, exp_rd_q.pop_front());
    end
  end

  // driver tasks (entered and left on a falling clk edge)
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] e, input string nm);
    exp_rd_q.push_back(e); exp_nm_q.push_back(nm);
    address = a; chipselect = 1'b1; write_n = 1'b1; sb_rd = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; sb_rd = 1'b0;
  endtask

  task automatic wait_idle(output int busy_n, output logic [31:0] st);
    bit ok;
    ok = 1'b0; busy_n = 0;
    address = 3'd2; chipselect = 1'b1; write_n = 1'b1;
    for (int i = 0; i < 4 * BUSY_LEN; i++) begin
      @(negedge clk);
      if (readdata[0]) busy_n++;
      else begin ok = 1'b1; break; end
    end
    chipselect = 1'b0;
    st = readdata;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", busy_n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          bn;
    logic [31:0] st;
    logic [7:0]  cmd, tx, rb;
    logic        prev_irq, got;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    sb_rd = 1'b0; m_oe = 1'b0; m_bit = 1'b0; m_rbyte = '0;
    exp_rx = '0; exp_tx = '0; exp_done = 1'b0; exp_irq_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ce", rtc_ce, 1'b0);
    check("reset sclk", rtc_sclk, 1'b0);
    check("reset readdata", readdata, 32'd0);
    check("reset irq", irq, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    // idle line released: the model alone sets its level
    m_oe = 1'b1; m_bit = 1'b0; #1;
    check("idle io low", rtc_io, 1'b0);
    m_bit = 1'b1; #1;
    check("idle io high", rtc_io, 1'b1);
    m_oe = 1'b0;
    @(negedge clk);
    bus_read(3'd2, st_exp(1'b0), "reset status");
    bus_read(3'd1, 32'd0, "reset data");
    bus_read(3'd5, 32'd0, "unmapped read");

    // directed write frame
    exp_tx = 8'h5A;
    bus_write(3'd1, 32'h5A);
    exp_frame_q.push_back(mk(8'h80, 8'h5A));
    bus_write(3'd0, 32'h80);
    wait_idle(bn, st);
    exp_done = 1'b1;
    check("write busy_len", bn, BUSY_LEN);
    check("write status", st, st_exp(1'b0));
    bus_write(3'd2, 32'h2); exp_done = 1'b0;
    bus_read(3'd2, st_exp(1'b0), "done cleared");

    // directed read frame
    m_rbyte = 8'h37;
    exp_frame_q.push_back(mk(8'h81, 8'h37));
    bus_write(3'd0, 32'h81);
    wait_idle(bn, st);
    exp_done = 1'b1; exp_rx = 8'h37;
    check("read busy_len", bn, BUSY_LEN);
    bus_read(3'd1, {24'd0, exp_rx}, "read data");

    // writes while busy, and a CMD write on the last RECOVER cycle, are ignored
    exp_tx = 8'hC3;
    bus_write(3'd1, 32'hC3);
    exp_frame_q.push_back(mk(8'h80, 8'hC3));
    bus_write(3'd0, 32'h80);
    repeat (19) @(negedge clk);
    bus_write(3'd0, 32'h81);
    bus_write(3'd1, 32'hFF);
    repeat (122) @(negedge clk);
    bus_write(3'd0, 32'h81);
    exp_done = 1'b1;
    bus_read(3'd2, st_exp(1'b0), "cmd at last recover");
    bus_read(3'd1, {24'd0, exp_rx}, "rx after busy writes");

    // done-clear on the completion cycle: set wins
    exp_frame_q.push_back(mk(8'h80, 8'hC3));
    bus_write(3'd0, 32'h80);
    repeat (143) @(negedge clk);
    bus_write(3'd2, 32'h2);
    bus_read(3'd2, st_exp(1'b0), "clear vs set");
    bus_write(3'd2, 32'h2); exp_done = 1'b0;

    // randomized frames
    for (int i = 0; i < 6; i++) begin
      cmd = 8'($urandom_range(0, 255));
      cmd[0] = i[0];
      tx  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(1, 255));
      m_rbyte = rb; exp_tx = tx;
      bus_write(3'd1, {24'd0, tx});
      exp_frame_q.push_back(mk(cmd, cmd[0] ? rb : tx));
      bus_write(3'd0, {24'd0, cmd});
      wait_idle(bn, st);
      exp_done = 1'b1;
      if (cmd[0]) exp_rx = rb;
      check("rand busy_len", bn, BUSY_LEN);
      check("rand status", st, st_exp(1'b0));
      bus_read(3'd1, {24'd0, exp_rx}, "rand data");
      bus_write(3'd2, 32'h2); exp_done = 1'b0;
    end

`ifdef RTC3W_IRQ_EN
    bus_write(3'd2, 32'h4); exp_irq_en = 1'b1;
    bus_read(3'd2, st_exp(1'b0), "status irq_en");
    exp_frame_q.push_back(mk(8'h80, exp_tx));
    bus_write(3'd0, 32'h80);
    address = 3'd2; chipselect = 1'b1; write_n = 1'b1;
    prev_irq = irq; got = 1'b0;
    for (int i = 0; i < 2 * BUSY_LEN; i++) begin
      @(negedge clk);
      if (readdata[1]) begin got = 1'b1; break; end
      prev_irq = irq;
    end
    chipselect = 1'b0;
    check("irq low before done", prev_irq, 1'b0);
    check("done seen", got, 1'b1);
    check("irq one clk after done", irq, 1'b1);
    exp_done = 1'b1;
    bus_write(3'd2, 32'h6); exp_done = 1'b0;
    check("irq held on clear edge", irq, 1'b1);
    @(negedge clk);
    check("irq falls after clear", irq, 1'b0);
    bus_read(3'd2, st_exp(1'b0), "status after clear");
    bus_write(3'd2, 32'h0); exp_irq_en = 1'b0;
`else
    bus_write(3'd2, 32'h4);
    bus_read(3'd2, st_exp(1'b0), "irq_en ignored");
`endif

    // reset during the high half of the 5th CMD bit
    bus_write(3'd0, 32'h80);
    bus_read(3'd1, {24'd0, exp_rx}, "rx mid frame");
    repeat (40) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset ce", rtc_ce, 1'b0);
    check("midreset sclk", rtc_sclk, 1'b0);
    check("midreset readdata", readdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_rx = '0; exp_tx = '0; exp_done = 1'b0; exp_irq_en = 1'b0;
    @(negedge clk);
    bus_read(3'd2, st_exp(1'b0), "status after reset");
    bus_read(3'd1, 32'd0, "rx after reset");
    exp_frame_q.push_back(mk(8'h80, 8'h00));
    bus_write(3'd0, 32'h80);
    wait_idle(bn, st);
    exp_done = 1'b1;
    check("post reset busy_len", bn, BUSY_LEN);
    check("post reset status", st, st_exp(1'b0));

    repeat (5) @(negedge clk);
    check("frames pending", exp_frame_q.size(), 0);
    check("reads pending", exp_rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
